// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Number of digits processed per operation.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit index width; one spare bit keeps N=1 legal.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  // Ripple the carry bit by bit through the digit.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: A and B captured from switches on button
// presses, result computed DIGIT bits per clock with registered outputs.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic             Sub,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int IDX_W = idx_width(N);
  localparam logic [WIDTH-1:0] DMASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  // Button synchronisers and edge detectors (released = 1)
  logic ldb_s1_q, ldb_s2_q, ldb_prev_q;
  logic run_s1_q, run_s2_q, run_prev_q;
  logic ldb_press, run_press;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] aval_q, aval_d;
  logic [WIDTH-1:0] bval_q, bval_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             cout, c_msb;
  logic             last_dig;
  int               base;

  assign ldb_press = ldb_prev_q & ~ldb_s2_q;
  assign run_press = run_prev_q & ~run_s2_q;
  assign last_dig  = (idx_q == IDX_W'(N - 1));

  // Select the current digit of each operand; B is inverted for subtraction.
  always_comb begin
    base  = DIGIT * int'(idx_q);
    a_dig = DIGIT'(aval_q >> base);
    b_dig = DIGIT'(bval_q >> base) ^ {DIGIT{sub_q}};
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (a_dig),
    .b        (b_dig),
    .cin      (carry_q),
    .s        (s_dig),
    .cout     (cout),
    .c_msb_in (c_msb)
  );

  // State and datapath registers; synchronisers reset to the released level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ldb_s1_q   <= 1'b1;
      ldb_s2_q   <= 1'b1;
      ldb_prev_q <= 1'b1;
      run_s1_q   <= 1'b1;
      run_s2_q   <= 1'b1;
      run_prev_q <= 1'b1;
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      aval_q     <= '0;
      bval_q     <= '0;
      shadow_q   <= '0;
      sum_q      <= '0;
      co_q       <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ldb_s1_q   <= LoadB;
      ldb_s2_q   <= ldb_s1_q;
      ldb_prev_q <= ldb_s2_q;
      run_s1_q   <= Run;
      run_s2_q   <= run_s1_q;
      run_prev_q <= run_s2_q;
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      sub_q      <= sub_d;
      aval_q     <= aval_d;
      bval_q     <= bval_d;
      shadow_q   <= shadow_d;
      sum_q      <= sum_d;
      co_q       <= co_d;
      ov_q       <= ov_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: one operation per Run press, wait for release in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_press) state_d = CALC;
      CALC:    if (last_dig)  state_d = HOLD;
      HOLD:    if (run_s2_q)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, digit accumulation and result/flag updates.
  always_comb begin
    aval_d   = aval_q;
    bval_d   = bval_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    co_d     = co_q;
    ov_d     = ov_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ldb_press) bval_d = SW;
        if (run_press) begin
          aval_d  = SW;
          sub_d   = Sub;
          carry_d = Sub;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        shadow_d = (shadow_q & ~(DMASK << base)) | (WIDTH'(s_dig) << base);
        carry_d  = cout;
        idx_d    = idx_q + 1'b1;
        if (last_dig) begin
          sum_d  = shadow_d;
          co_d   = cout;
          ov_d   = c_msb ^ cout;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      HOLD: begin
        if (ldb_press) bval_d = SW;
      end
      default: ;
    endcase
  end

  assign Aval = aval_q;
  assign Bval = bval_q;
  assign Sum  = sum_q;
  assign CO   = co_q;
  assign OV   = ov_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench driving three adder instances (DIGIT = 4, 1, 16) in parallel.
module tb_digit_serial_adder;

  logic        Clk = 1'b0;
  logic        Reset, LoadB, Run, Sub;
  logic [15:0] SW;

  logic [15:0] aval_o[3], bval_o[3], sum_o[3];
  logic        co_o[3], ov_o[3], busy_o[3], done_o[3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
    .Aval(aval_o[0]), .Bval(bval_o[0]), .Sum(sum_o[0]), .CO(co_o[0]),
    .OV(ov_o[0]), .Busy(busy_o[0]), .Done(done_o[0]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
    .Aval(aval_o[1]), .Bval(bval_o[1]), .Sum(sum_o[1]), .CO(co_o[1]),
    .OV(ov_o[1]), .Busy(busy_o[1]), .Done(done_o[1]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
    .Aval(aval_o[2]), .Bval(bval_o[2]), .Sum(sum_o[2]), .CO(co_o[2]),
    .OV(ov_o[2]), .Busy(busy_o[2]), .Done(done_o[2]));

  // Digits per operation for instance k.
  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_aval"}, k, 32'(aval_o[k]), 32'h0);
      chk({tag, "_bval"}, k, 32'(bval_o[k]), 32'h0);
      chk({tag, "_sum"},  k, 32'(sum_o[k]),  32'h0);
      chk({tag, "_co"},   k, 32'(co_o[k]),   32'h0);
      chk({tag, "_ov"},   k, 32'(ov_o[k]),   32'h0);
      chk({tag, "_busy"}, k, 32'(busy_o[k]), 32'h0);
      chk({tag, "_done"}, k, 32'(done_o[k]), 32'h0);
    end
  endtask

  task automatic load_b(input logic [15:0] b);
    SW    = b;
    LoadB = 1'b0;
    repeat (5) tick();
    LoadB = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) chk("loadb_bval", k, 32'(bval_o[k]), 32'(b));
  endtask

  // Press Run with SW=a; Run goes low #1 after an edge, so Done is due in
  // sample 3+N and Busy is seen for N samples.
  task automatic run_op(input string tag, input logic [15:0] a, input logic sub,
                        input logic [15:0] es, input logic eco, input logic eov);
    int first[3];
    int dones[3];
    int busys[3];
    for (int k = 0; k < 3; k++) begin
      first[k] = -1;
      dones[k] = 0;
      busys[k] = 0;
    end
    SW  = a;
    Sub = sub;
    Run = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (done_o[k] === 1'b1) begin
          dones[k]++;
          if (first[k] < 0) first[k] = c;
        end
        if (busy_o[k] === 1'b1) busys[k]++;
      end
      if (c == 6) Run = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_sum"},     k, 32'(sum_o[k]),  32'(es));
      chk({tag, "_co"},      k, 32'(co_o[k]),   32'(eco));
      chk({tag, "_ov"},      k, 32'(ov_o[k]),   32'(eov));
      chk({tag, "_aval"},    k, 32'(aval_o[k]), 32'(a));
      chk({tag, "_ndone"},   k, 32'(dones[k]),  32'd1);
      chk({tag, "_latency"}, k, 32'(first[k]),  32'(3 + n_of(k)));
      chk({tag, "_busy"},    k, 32'(busys[k]),  32'(n_of(k)));
    end
  endtask

  initial begin
    int dones[3];
    int act;

    Reset = 1'b0;
    LoadB = 1'b1;
    Run   = 1'b1;
    Sub   = 1'b0;
    SW    = 16'h0;
    repeat (3) tick();
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (3) tick();

    // Basic add, latency and busy length
    load_b(16'h0002);
    run_op("t1_add", 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Carry out and signed overflow on add
    load_b(16'h0001);
    run_op("t2_wrap", 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2_ovf",  16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Subtraction with borrow and with overflow
    load_b(16'h0007);
    run_op("t3_borrow", 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    load_b(16'h0001);
    run_op("t3_ovf",    16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Run held 30 cycles; LoadB presses during CALC and during HOLD
    for (int k = 0; k < 3; k++) dones[k] = 0;
    SW  = 16'h0003;
    Sub = 1'b0;
    Run = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int k = 0; k < 3; k++) if (done_o[k] === 1'b1) dones[k]++;
      if (c == 3) begin
        SW    = 16'h1234;
        LoadB = 1'b0;
      end
      if (c == 8) LoadB = 1'b1;
      if (c == 12) begin
        chk("t4_busy_loadb", 0, 32'(bval_o[0]), 32'h0001);
        chk("t4_busy_loadb", 1, 32'(bval_o[1]), 32'h0001);
        chk("t4_hold_loadb", 2, 32'(bval_o[2]), 32'h1234);
      end
      if (c == 22) LoadB = 1'b0;
      if (c == 27) LoadB = 1'b1;
      if (c == 30) begin
        for (int k = 0; k < 3; k++) chk("t4_hold_loadb", k, 32'(bval_o[k]), 32'h1234);
        Run = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk("t4_one_done", k, 32'(dones[k]), 32'd1);
      chk("t4_sum", k, 32'(sum_o[k]), 32'h0004);
    end

    // Reset in the second CALC cycle of the DIGIT=4 instance
    load_b(16'h0000);
    act = 0;
    SW  = 16'h00FF;
    Run = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 4) begin
        Reset = 1'b0;
        Run   = 1'b1;
        #1;
        check_all_zero("t5_midreset");
      end
      if (c == 6) Reset = 1'b1;
      if (c >= 5) begin
        if (done_o[0] === 1'b1 || done_o[1] === 1'b1) act++;
        for (int k = 0; k < 3; k++) if (busy_o[k] !== 1'b0) act++;
      end
    end
    chk("t5_no_done", 0, 32'(act), 32'd0);
    load_b(16'h0000);
    run_op("t5_after", 16'h0009, 1'b0, 16'h0009, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
